// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Write-back arbiter and busy scoreboard for the 31-entry integer GPR file.
//   Three result producers (0 = ALU, 1 = mul/div, 2 = FPU int results) share
//   the single GPR write port under round-robin arbitration. A per-register
//   busy bit is set when decode issues a writer and cleared when the write
//   reaches the GPR port. The busy bits produce RAW and WAW stalls for decode.
//
// Ports
//   clk, rst_l                     clock, asynchronous active-low reset
//   issue_valid/issue_waddr        decode issuing a writer of issue_waddr
//   issue_stall                    comb: destination still busy (WAW)
//   rden0/raddr0, rden1/raddr1     decode source operand reads
//   read_stall                     comb: a source operand is busy (RAW)
//   req_valid/req_waddr/req_wdata  per-producer write-back requests (packed)
//   req_ready                      comb one-hot grant
//   wen0/waddr0/wd0                registered GPR write port
//   busy_vec                       scoreboard, bit j-1 = register j busy
//
// Handshake: a producer transfers when req_valid[i] & req_ready[i] are both
// high at a rising edge. req_ready depends only on req_valid and the
// round-robin pointer. A producer that is not granted must hold valid,
// address and data stable; there is no internal buffering.
module gpr_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              issue_valid,
  input  logic [4:0]        issue_waddr,
  output logic              issue_stall,
  input  logic              rden0,
  input  logic [4:0]        raddr0,
  input  logic              rden1,
  input  logic [4:0]        raddr1,
  output logic              read_stall,
  input  logic [2:0]        req_valid,
  input  logic [14:0]       req_waddr,
  input  logic [3*XLEN-1:0] req_wdata,
  output logic [2:0]        req_ready,
  output logic              wen0,
  output logic [4:0]        waddr0,
  output logic [XLEN-1:0]   wd0,
  output logic [30:0]       busy_vec
);

  // Round-robin pointer: producer searched first this cycle (0, 1 or 2).
  logic [1:0]      rr_ptr;
  logic [1:0]      rr_next;

  logic [1:0]      ord0, ord1, ord2;
  logic            grant_any;
  logic [1:0]      grant_idx;
  logic [4:0]      sel_waddr;
  logic [XLEN-1:0] sel_wdata;

  // Bit 0 stands for x0 and is never set; it exists so every 5-bit address
  // can index the vector directly.
  logic [31:0]     busy_q;
  logic [31:0]     busy_next;
  logic            issue_fire;

  logic [4:0]      waddr_arr [3];
  logic [XLEN-1:0] wdata_arr [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      waddr_arr[i] = req_waddr[5*i +: 5];
      wdata_arr[i] = req_wdata[XLEN*i +: XLEN];
    end
  end

  // Search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  always_comb begin
    case (rr_ptr)
      2'd1:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd2:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
  end

  always_comb begin
    grant_any = 1'b1;
    grant_idx = ord0;
    if (req_valid[ord0])      grant_idx = ord0;
    else if (req_valid[ord1]) grant_idx = ord1;
    else if (req_valid[ord2]) grant_idx = ord2;
    else                      grant_any = 1'b0;
  end

  always_comb begin
    req_ready = 3'b000;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_waddr = waddr_arr[grant_idx];
    sel_wdata = wdata_arr[grant_idx];
  end

  always_comb begin
    case (grant_idx)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  end

  // Pointer and registered write port. A grant to x0 is consumed but does
  // not raise wen0.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr <= 2'd0;
      wen0   <= 1'b0;
      waddr0 <= 5'd0;
      wd0    <= '0;
    end else begin
      wen0 <= grant_any && (sel_waddr != 5'd0);
      if (grant_any) begin
        rr_ptr <= rr_next;
        waddr0 <= sel_waddr;
        wd0    <= sel_wdata;
      end
    end
  end

  // Scoreboard
  assign issue_stall = issue_valid && (issue_waddr != 5'd0) && busy_q[issue_waddr];
  assign issue_fire  = issue_valid && (issue_waddr != 5'd0) && !busy_q[issue_waddr];

  assign read_stall = (rden0 && (raddr0 != 5'd0) && busy_q[raddr0]) ||
                      (rden1 && (raddr1 != 5'd0) && busy_q[raddr1]);

  // Clear is applied first so a same-register set wins.
  always_comb begin
    busy_next = busy_q;
    if (wen0)       busy_next[waddr0]      = 1'b0;
    if (issue_fire) busy_next[issue_waddr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) busy_q <= '0;
    else        busy_q <= busy_next;
  end

  assign busy_vec = busy_q[31:1];

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter
//   Drives gpr_wb_arbiter with directed sequences followed by randomized
//   traffic. A reference model computes grants and scoreboard state from the
//   arbitration rules; the expected write-port value for every cycle is
//   pushed into exp_q and a separate monitor pops and compares it.
module tb_gpr_wb_arbiter;
  localparam int XLEN = 32;
  localparam int W    = 1 + 5 + XLEN;

  logic              clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              issue_valid = 1'b0;
  logic [4:0]        issue_waddr = '0;
  logic              issue_stall;
  logic              rden0 = 1'b0;
  logic [4:0]        raddr0 = '0;
  logic              rden1 = 1'b0;
  logic [4:0]        raddr1 = '0;
  logic              read_stall;
  logic [2:0]        req_valid = '0;
  logic [14:0]       req_waddr = '0;
  logic [3*XLEN-1:0] req_wdata = '0;
  logic [2:0]        req_ready;
  logic              wen0;
  logic [4:0]        waddr0;
  logic [XLEN-1:0]   wd0;
  logic [30:0]       busy_vec;

  gpr_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_l(rst_l),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr), .issue_stall(issue_stall),
    .rden0(rden0), .raddr0(raddr0), .rden1(rden1), .raddr1(raddr1),
    .read_stall(read_stall),
    .req_valid(req_valid), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0), .busy_vec(busy_vec)
  );

  // clock
  initial forever #5 clk = ~clk;

  // scoreboard state
  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  exp_q[$];

  // reference model
  int              m_ptr;
  bit              m_busy [32];
  bit              m_pend_v;
  int              m_pend_a;
  logic [4:0]      m_wa;
  logic [XLEN-1:0] m_wd;
  logic [2:0]      last_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int j = 0; j < 32; j++) m_busy[j] = 1'b0;
    m_pend_v = 1'b0;
    m_pend_a = 0;
    m_wa = '0;
    m_wd = '0;
    last_grant = '0;
  endtask

  // Holds reset with all producers requesting, checks the reset state, then
  // releases reset at posedge+1 and returns there.
  task automatic do_reset();
    rst_l = 1'b0;
    issue_valid = 1'b0; rden0 = 1'b0; rden1 = 1'b0;
    req_valid = 3'b111; req_waddr = {5'd3, 5'd2, 5'd1}; req_wdata = {32'h3, 32'h2, 32'h1};
    repeat (2) @(posedge clk);
    #4;
    chk("rst_req_ready", 64'(req_ready), 64'(3'b001));
    chk("rst_wen0", 64'(wen0), 64'(1'b0));
    chk("rst_wd0", 64'(wd0), 64'(0));
    chk("rst_waddr0", 64'(waddr0), 64'(0));
    chk("rst_busy_vec", 64'(busy_vec), 64'(0));
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    model_reset();
    exp_q.delete();
    exp_q.push_back('0);
    rst_l = 1'b1;
  endtask

  // One cycle: called at posedge+1, applies inputs, checks combinational
  // outputs against the model, advances the model, returns at next posedge+1.
  task automatic step(input logic iv, input logic [4:0] ia,
                      input logic r0e, input logic [4:0] r0a,
                      input logic r1e, input logic [4:0] r1a,
                      input logic [2:0] rv, input logic [14:0] ra,
                      input logic [3*XLEN-1:0] rd);
    int g;
    int p;
    logic [2:0]  e_ready;
    logic [30:0] e_busy;
    bit          e_istall, e_rstall, fire;
    issue_valid = iv; issue_waddr = ia;
    rden0 = r0e; raddr0 = r0a; rden1 = r1e; raddr1 = r1a;
    req_valid = rv; req_waddr = ra; req_wdata = rd;
    #3;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      p = (m_ptr + k) % 3;
      if (g < 0 && rv[p]) g = p;
    end
    e_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
    for (int j = 1; j < 32; j++) e_busy[j-1] = m_busy[j];
    e_istall = iv && (ia != 0) && m_busy[ia];
    e_rstall = (r0e && (r0a != 0) && m_busy[r0a]) || (r1e && (r1a != 0) && m_busy[r1a]);
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("busy_vec", 64'(busy_vec), 64'(e_busy));
    chk("issue_stall", 64'(issue_stall), 64'(e_istall));
    chk("read_stall", 64'(read_stall), 64'(e_rstall));
    fire = iv && (ia != 0) && !m_busy[ia];
    if (m_pend_v) m_busy[m_pend_a] = 1'b0;
    if (fire) m_busy[ia] = 1'b1;
    if (g >= 0) begin
      m_wa = ra[5*g +: 5];
      m_wd = rd[XLEN*g +: XLEN];
      m_pend_v = (m_wa != 0);
      m_pend_a = int'(m_wa);
      m_ptr = (g + 1) % 3;
    end else begin
      m_pend_v = 1'b0;
    end
    exp_q.push_back({m_pend_v, m_wa, m_wd});
    last_grant = e_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 15'd0, '0);
  endtask

  // monitor: one expected write-port value per cycle out of reset
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_l === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_queue: got empty expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("wen0", 64'(wen0), 64'(e[W-1]));
        chk("waddr0", 64'(waddr0), 64'(e[W-2 -: 5]));
        chk("wd0", 64'(wd0), 64'(e[XLEN-1:0]));
      end
    end
  end

  logic            pv [3];
  logic [4:0]      pa [3];
  logic [XLEN-1:0] pd [3];

  initial begin
    logic [2:0]        rv;
    logic [14:0]       ra;
    logic [3*XLEN-1:0] rd;
    do_reset();

    // round robin with all producers requesting
    repeat (4) step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b111,
                    {5'd3, 5'd2, 5'd1}, {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
    idle();

    // single requester
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b100, {5'd7, 10'd0}, {32'hDEADBEEF, 64'd0});
    idle();
    idle();

    // RAW through x5
    step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 15'd0, '0);
    step(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 3'b000, 15'd0, '0);
    step(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd3, 3'b001, {10'd0, 5'd5}, {64'd0, 32'h12345678});
    step(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 3'b000, 15'd0, '0);
    step(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 3'b000, 15'd0, '0);

    // WAW and x0
    step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 15'd0, '0);
    step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 15'd0, '0);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 3'b000, 15'd0, '0);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b010, 15'd0, {32'd0, 32'h0BAD0BAD, 32'd0});
    idle();

    // asynchronous reset while a write is on the port
    step(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 15'd0, '0);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b100, {5'd9, 10'd0}, {32'h0000F00D, 64'd0});
    issue_valid = 1'b0; rden0 = 1'b0; rden1 = 1'b0; req_valid = 3'b000;
    #1;
    chk("pre_rst_wen0", 64'(wen0), 64'(1'b1));
    rst_l = 1'b0;
    #1;
    chk("async_rst_wen0", 64'(wen0), 64'(1'b0));
    chk("async_rst_busy", 64'(busy_vec), 64'(0));
    do_reset();

    // randomized traffic with protocol-compliant producers
    for (int p = 0; p < 3; p++) begin pv[p] = 1'b0; pa[p] = '0; pd[p] = '0; end
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 3; p++) begin
        if (pv[p] && last_grant[p]) pv[p] = 1'b0;
        if (!pv[p] && $urandom_range(0, 99) < 55) begin
          pv[p] = 1'b1;
          pa[p] = 5'($urandom_range(0, 7));
          pd[p] = $urandom;
        end
        rv[p] = pv[p];
        ra[5*p +: 5] = pa[p];
        rd[XLEN*p +: XLEN] = pd[p];
      end
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           rv, ra, rd);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
